// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: three-requester write arbiter in front of a register bank.
// Each cycle one eligible requester is picked. A requester is eligible when its
// req is high and it is not being granted in that cycle. The winner's grant,
// one-hot load strobe and data are registered, so they appear one cycle later.
// A saturating counter records cycles with two or more eligible requesters.
// Build option: define RR_ARB_EN for round-robin arbitration. Without it, the
// arbiter uses fixed priority req0 > req1 > req2.
module reg_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  localparam int NUM_REGS = 2**ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            req,
  input  logic [3*ADDR_W-1:0]   wr_addr,
  input  logic [3*DATA_W-1:0]   wr_data,
  input  logic                  cnt_clr,
  output logic [2:0]            gnt,
  output logic [NUM_REGS-1:0]   load,
  output logic [DATA_W-1:0]     bus_data,
  output logic [7:0]            conflict_cnt
);

  logic [2:0]        eligible;
  logic              contended;
  logic              win_valid;
  logic [1:0]        win_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // A requester granted this cycle has already been served, so mask it out.
  assign eligible  = req & ~gnt;
  assign contended = (eligible[0] & eligible[1]) |
                     (eligible[0] & eligible[2]) |
                     (eligible[1] & eligible[2]);

`ifdef RR_ARB_EN
  logic [1:0] last_gnt;
  logic [1:0] cand;

  // Round-robin pick: search starts after the last winner and wraps 2 -> 0.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = (last_gnt == 2'd2) ? 2'd0 : last_gnt + 2'd1;
    for (int k = 0; k < 3; k++) begin
      if (!win_valid && eligible[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  end

  // Remember the most recent winner. Reset value 2 gives requester 0 first turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 2'd2;
    end else if (win_valid) begin
      last_gnt <= win_idx;
    end
  end
`else
  // Fixed priority pick: the lowest-numbered eligible requester wins.
  always_comb begin
    win_valid = 1'b1;
    win_idx   = 2'd0;
    if (eligible[0]) begin
      win_idx = 2'd0;
    end else if (eligible[1]) begin
      win_idx = 2'd1;
    end else if (eligible[2]) begin
      win_idx = 2'd2;
    end else begin
      win_valid = 1'b0;
    end
  end
`endif

  // Route the winner's address and data toward the output registers.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    case (win_idx)
      2'd0: begin
        sel_addr = wr_addr[0 +: ADDR_W];
        sel_data = wr_data[0 +: DATA_W];
      end
      2'd1: begin
        sel_addr = wr_addr[ADDR_W +: ADDR_W];
        sel_data = wr_data[DATA_W +: DATA_W];
      end
      2'd2: begin
        sel_addr = wr_addr[2*ADDR_W +: ADDR_W];
        sel_data = wr_data[2*DATA_W +: DATA_W];
      end
      default: begin
        sel_addr = '0;
        sel_data = '0;
      end
    endcase
  end

  // Registered grant and load strobes. bus_data keeps its value when nothing wins.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
    if (!rst_n) begin
      gnt      <= '0;
      load     <= '0;
      bus_data <= '0;
    end else begin
      gnt  <= '0;
      load <= '0;
      if (win_valid) begin
        gnt      <= 3'b001 << win_idx;
        load     <= NUM_REGS'(1) << sel_addr;
        bus_data <= sel_data;
      end
    end
  end

  // Saturating contention counter. A clear overrides an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= 8'd0;
    end else if (cnt_clr) begin
      conflict_cnt <= 8'd0;
    end else if (contended && conflict_cnt != 8'hFF) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: scoreboard bench for reg_write_arbiter.
// Each stimulus cycle pushes the expected outputs for the following cycle.
// Those expectations come from an arbitration model kept in the bench. A
// separate monitor pops each entry and compares it with the DUT.
// The bench follows the RR_ARB_EN build option so it matches the DUT.
module tb_reg_write_arbiter;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NUM_REGS = 2**ADDR_W;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2:0]          req;
  logic [3*ADDR_W-1:0] wr_addr;
  logic [3*DATA_W-1:0] wr_data;
  logic                cnt_clr;
  logic [2:0]          gnt;
  logic [NUM_REGS-1:0] load;
  logic [DATA_W-1:0]   bus_data;
  logic [7:0]          conflict_cnt;

  reg_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .cnt_clr(cnt_clr), .gnt(gnt), .load(load), .bus_data(bus_data),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]          gnt;
    logic [NUM_REGS-1:0] load;
    logic [DATA_W-1:0]   bus;
    logic [7:0]          cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model state: the outputs the DUT should currently show.
  logic [2:0]          m_gnt;
  logic [NUM_REGS-1:0] m_load;
  logic [DATA_W-1:0]   m_bus;
  int                  m_cnt;
  int                  m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_gnt = '0; m_load = '0; m_bus = '0; m_cnt = 0; m_last = 2;
  endtask

  // Arbitration rule from the requirements: who goes next among the eligible set.
  function automatic int pick(input logic [2:0] elig);
`ifdef RR_ARB_EN
    for (int k = 1; k <= 3; k++) begin
      int j;
      j = (m_last + k) % 3;
      if (elig[j]) return j;
    end
`else
    for (int j = 0; j < 3; j++) if (elig[j]) return j;
`endif
    return -1;
  endfunction

  // Drive one cycle of inputs, advance the model, and push the expected outputs.
  task automatic step(input logic [2:0] r, input logic [3*ADDR_W-1:0] a,
                      input logic [3*DATA_W-1:0] d, input logic clr);
    logic [2:0] elig;
    int w;
    exp_t e;
    req = r; wr_addr = a; wr_data = d; cnt_clr = clr;
    elig = r & ~m_gnt;
    w = pick(elig);
    if (clr) m_cnt = 0;
    else if ($countones(elig) >= 2 && m_cnt < 255) m_cnt = m_cnt + 1;
    if (w >= 0) begin
      int ad;
      ad = int'(a[w*ADDR_W +: ADDR_W]);
      m_gnt  = 3'(1 << w);
      m_load = NUM_REGS'(1 << ad);
      m_bus  = d[w*DATA_W +: DATA_W];
      m_last = w;
    end else begin
      m_gnt  = '0;
      m_load = '0;
    end
    @(posedge clk);
    e.gnt = m_gnt; e.load = m_load; e.bus = m_bus; e.cnt = 8'(m_cnt);
    sb_q.push_back(e);
    #1;
  endtask

  // Monitor: compare the DUT against each expected entry, halfway through the cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("sb_gnt", 32'(gnt), 32'(e.gnt));
      check("sb_load", 32'(load), 32'(e.load));
      check("sb_bus_data", 32'(bus_data), 32'(e.bus));
      check("sb_conflict_cnt", 32'(conflict_cnt), 32'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [2:0] seq[6];
  logic [2:0] exp_seq[6];
  bit   [2:0] pend;
  logic [ADDR_W-1:0] pa[3];
  logic [DATA_W-1:0] pd[3];

  initial begin
    rst_n = 1'b0; req = '0; wr_addr = '0; wr_data = '0; cnt_clr = 1'b0;
    model_reset();
    #2;
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_load", 32'(load), 32'd0);
    check("reset_bus_data", 32'(bus_data), 32'd0);
    check("reset_cnt", 32'(conflict_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write from requester 0, followed by an idle cycle.
    step(3'b001, {3'd0, 3'd0, 3'd5}, {16'h0, 16'h0, 16'hA5A5}, 1'b0);
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_load", 32'(load), 32'h20);
    check("single_bus", 32'(bus_data), 32'hA5A5);
    step(3'b000, '0, '0, 1'b0);
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_bus_hold", 32'(bus_data), 32'hA5A5);

    // All three requesters held high: the grant pattern depends on the arbitration mode.
    step(3'b000, '0, '0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(3'b111, {3'd2, 3'd1, 3'd0}, {16'h3333, 16'h2222, 16'h1111}, 1'b0);
      seq[i] = gnt;
    end
`ifdef RR_ARB_EN
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
    exp_seq = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
`endif
    for (int i = 0; i < 6; i++) check($sformatf("held_gnt_%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    check("held_cnt", 32'(conflict_cnt), 32'd6);

    // Each requester drops req one cycle after it sees its grant.
    step(3'b000, '0, '0, 1'b1);
    step(3'b111, {3'd6, 3'd5, 3'd4}, {16'hC0C0, 16'hB0B0, 16'hA0A0}, 1'b0);
    check("order_g0", 32'(gnt), 32'b001);
    step(3'b111, {3'd6, 3'd5, 3'd4}, {16'hC0C0, 16'hB0B0, 16'hA0A0}, 1'b0);
    check("order_g1", 32'(gnt), 32'b010);
    step(3'b110, {3'd6, 3'd5, 3'd4}, {16'hC0C0, 16'hB0B0, 16'hA0A0}, 1'b0);
    check("order_g2", 32'(gnt), 32'b100);
    step(3'b100, {3'd6, 3'd5, 3'd4}, {16'hC0C0, 16'hB0B0, 16'hA0A0}, 1'b0);
    check("order_cnt", 32'(conflict_cnt), 32'd2);
    step(3'b000, '0, '0, 1'b0);

    // Two requesters write the same address on consecutive cycles.
    step(3'b010, {3'd0, 3'd3, 3'd0}, {16'h0, 16'h1111, 16'h0}, 1'b0);
    check("same_addr_load1", 32'(load), 32'h08);
    check("same_addr_bus1", 32'(bus_data), 32'h1111);
    step(3'b100, {3'd3, 3'd0, 3'd0}, {16'h2222, 16'h0, 16'h0}, 1'b0);
    check("same_addr_load2", 32'(load), 32'h08);
    check("same_addr_bus2", 32'(bus_data), 32'h2222);
    step(3'b000, '0, '0, 1'b0);

    // Assert reset between clock edges while a grant is being shown.
    step(3'b010, {3'd0, 3'd7, 3'd0}, {16'h0, 16'hBEEF, 16'h0}, 1'b0);
    check("pre_reset_gnt", 32'(gnt), 32'b010);
    sb_q.delete();
    rst_n = 1'b0;
    #1;
    check("midreset_gnt", 32'(gnt), 32'd0);
    check("midreset_load", 32'(load), 32'd0);
    check("midreset_bus", 32'(bus_data), 32'd0);
    check("midreset_cnt", 32'(conflict_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req = '0;
    model_reset();
    step(3'b001, {3'd0, 3'd0, 3'd1}, {16'h0, 16'h0, 16'h5555}, 1'b0);
    check("post_reset_gnt", 32'(gnt), 32'b001);

    // Counter saturation, then a clear in a cycle that is also contended.
    step(3'b000, '0, '0, 1'b1);
    for (int i = 0; i < 300; i++)
      step(3'b111, {3'd1, 3'd2, 3'd3}, {16'h0C0C, 16'h0B0B, 16'h0A0A}, 1'b0);
    check("sat_cnt", 32'(conflict_cnt), 32'd255);
    step(3'b111, {3'd1, 3'd2, 3'd3}, {16'h0C0C, 16'h0B0B, 16'h0A0A}, 1'b1);
    check("clr_wins", 32'(conflict_cnt), 32'd0);
    step(3'b000, '0, '0, 1'b0);

    // Random phase: each requester holds its request until it is granted.
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      logic [3*ADDR_W-1:0] av;
      logic [3*DATA_W-1:0] dv;
      for (int i = 0; i < 3; i++) begin
        if (pend[i] && m_gnt[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          pa[i] = ADDR_W'($urandom);
          pd[i] = DATA_W'($urandom);
        end
        av[i*ADDR_W +: ADDR_W] = pa[i];
        dv[i*DATA_W +: DATA_W] = pd[i];
      end
      step(pend, av, dv, $urandom_range(0, 15) == 0);
    end
    step(3'b000, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
